udp_pkt_gen: RTL

UDP_PKT_GEN -- requirements
Module: udp_pkt_gen

---
 rtl/udp_pkt_gen.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/udp_pkt_gen.sv
// UDP test-packet generator: emits a header then a numbered payload on trigger
// or on a programmable period, with a single collapsing request flag.
module udp_pkt_gen #(
  parameter int MAX_LEN = 1472
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_enable,
  input  logic [31:0] cfg_period,
  input  logic        trigger,
  input  logic [31:0] cfg_dest_ip,
  input  logic [15:0] cfg_src_port,
  input  logic [15:0] cfg_dest_port,
  input  logic [15:0] cfg_len,
  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [31:0] m_udp_ip_dest_ip,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  output logic [15:0] m_udp_length,
  output logic [7:0]  m_udp_payload_axis_tdata,
  output logic        m_udp_payload_axis_tvalid,
  input  logic        m_udp_payload_axis_tready,
  output logic        m_udp_payload_axis_tlast,
  output logic        busy,
  output logic [31:0] seq_num,
  output logic [31:0] pkt_count
);

  localparam logic [1:0]  IDLE      = 2'd0;
  localparam logic [1:0]  HDR       = 2'd1;
  localparam logic [1:0]  PAYLOAD   = 2'd2;
  localparam logic [15:0] MIN_LEN   = 16'd4;
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  logic [1:0]  r_state;
  logic        r_pending;
  logic        r_armed;
  logic [31:0] r_timer;
  logic [15:0] r_idx;
  logic [15:0] r_last_idx;
  logic [15:0] r_udp_length;
  logic [31:0] r_dest_ip;
  logic [15:0] r_src_port;
  logic [15:0] r_dest_port;
  logic [31:0] r_seq_num;
  logic [31:0] r_pkt_count;

  logic        w_timer_run;
  logic        w_timer_hit;
  logic        w_start;
  logic        w_last;
  logic [15:0] w_len;
  logic [7:0]  w_data;

  assign w_timer_run = cfg_enable && (cfg_period != 32'd0);
  // r_armed masks the first post-reset cycle, where a period of 1 would otherwise fire.
  assign w_timer_hit = w_timer_run && r_armed && (r_timer >= cfg_period - 32'd1);
  assign w_start     = (r_state == IDLE) && r_pending;
  assign w_last      = (r_state == PAYLOAD) && (r_idx == r_last_idx);

  assign w_len = (cfg_len < MIN_LEN)   ? MIN_LEN   :
                 (cfg_len > MAX_LEN_W) ? MAX_LEN_W : cfg_len;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_data = 8'h00;
    if (r_state == PAYLOAD) begin
      case (r_idx)
        16'd0:   w_data = r_seq_num[31:24];
        16'd1:   w_data = r_seq_num[23:16];
        16'd2:   w_data = r_seq_num[15:8];
        16'd3:   w_data = r_seq_num[7:0];
        default: w_data = r_idx[7:0];
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
      r_timer <= 32'd0;
    end else begin
      r_armed <= 1'b1;
      if (!w_timer_run) begin
        r_timer <= 32'd0;
      end else if (r_timer >= cfg_period - 32'd1) begin
        r_timer <= 32'd0;
      end else begin
        r_timer <= r_timer + 32'd1;
      end
    end
  end

  // A new request in the same cycle as the clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else if (trigger || w_timer_hit) begin
      r_pending <= 1'b1;
    end else if (w_start) begin
      r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_idx        <= 16'd0;
      r_last_idx   <= 16'd0;
      r_udp_length <= 16'd0;
      r_dest_ip    <= 32'd0;
      r_src_port   <= 16'd0;
      r_dest_port  <= 16'd0;
      r_seq_num    <= 32'd0;
      r_pkt_count  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_pending) begin
            r_state      <= HDR;
            r_dest_ip    <= cfg_dest_ip;
            r_src_port   <= cfg_src_port;
            r_dest_port  <= cfg_dest_port;
            r_last_idx   <= w_len - 16'd1;
            r_udp_length <= w_len + 16'd8;
          end
        end
        HDR: begin
          if (m_udp_hdr_ready) begin
            r_state <= PAYLOAD;
            r_idx   <= 16'd0;
          end
        end
        PAYLOAD: begin
          if (m_udp_payload_axis_tready) begin
            if (w_last) begin
              r_state     <= IDLE;
              r_idx       <= 16'd0;
              r_seq_num   <= r_seq_num + 32'd1;
              r_pkt_count <= r_pkt_count + 32'd1;
            end else begin
              r_idx <= r_idx + 16'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_udp_hdr_valid           = (r_state == HDR);
  assign m_udp_ip_dest_ip          = r_dest_ip;
  assign m_udp_source_port         = r_src_port;
  assign m_udp_dest_port           = r_dest_port;
  assign m_udp_length              = r_udp_length;
  assign m_udp_payload_axis_tdata  = w_data;
  assign m_udp_payload_axis_tvalid = (r_state == PAYLOAD);
  assign m_udp_payload_axis_tlast  = w_last;
  assign busy                      = (r_state != IDLE);
  assign seq_num                   = r_seq_num;
  assign pkt_count                 = r_pkt_count;

endmodule
